// File: rtl/mole_round_scheduler.sv
// mole_round_scheduler
//
// Runs one whack-a-mole game across NUM_MOLES LEDs. After a start pulse the
// scheduler alternates between an all-dark GAP phase (GAP_MS milliseconds)
// and an UP phase, where one pseudo-randomly chosen mole is lit for up_ms
// milliseconds. Each UP phase ends with a hit (the matching button pulse) or
// a miss (the window runs out). The game ends after ROUNDS pop-ups.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   ms_tick      one-cycle pulse per millisecond
//   start        one-cycle pulse, begins a game from IDLE or DONE
//   up_ms        mole-up window in ms, sampled when a mole pops up
//   buttons      debounced one-cycle press pulses, one bit per mole
//   leds         one-hot lit mole, or all zero
//   active_mole  index of the current (or most recent) mole
//   score        hits this game, saturating at 255
//   misses       timeouts this game, saturating at 255
//   busy         high while a game is in progress (GAP or UP)
//   game_over    high once the game has finished (DONE)

module mole_round_scheduler #(
  parameter int         NUM_MOLES = 4,
  parameter int         MAX_MS    = 2047,
  parameter int         GAP_MS    = 500,
  parameter int         ROUNDS    = 20,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ms_tick,
  input  logic                         start,
  input  logic [$clog2(MAX_MS)-1:0]    up_ms,
  input  logic [NUM_MOLES-1:0]         buttons,
  output logic [NUM_MOLES-1:0]         leds,
  output logic [$clog2(NUM_MOLES)-1:0] active_mole,
  output logic [7:0]                   score,
  output logic [7:0]                   misses,
  output logic                         busy,
  output logic                         game_over
);

  localparam int TW = $clog2(MAX_MS);
  localparam int MW = $clog2(NUM_MOLES);

  // A zero-length phase would never expire, so it is stretched to 1 ms.
  localparam logic [TW-1:0] GAP_LOAD = (GAP_MS == 0) ? TW'(1) : TW'(GAP_MS);
  localparam logic [7:0]    ROUNDS_L = 8'(ROUNDS);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    UP,
    DONE
  } state_t;

  state_t        state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [7:0]    round_cnt, round_cnt_d;
  logic [7:0]    score_q, score_d;
  logic [7:0]    misses_q, misses_d;
  logic [7:0]    lfsr, lfsr_d;
  logic [MW-1:0] mole, mole_d;

  logic          expire;
  logic          hit;
  logic [TW-1:0] up_load;
  logic [7:0]    next_cnt;
  logic [MW-1:0] pick;

  // A phase ends on the tick that would take the timer from 1 to 0, so a
  // load of N lasts exactly N ticks.
  assign expire   = ms_tick && (timer == TW'(1));
  assign hit      = buttons[mole];
  assign up_load  = (up_ms == '0) ? TW'(1) : up_ms;
  assign next_cnt = round_cnt + 8'd1;

  // Candidate mole from the LFSR low bits. If it repeats the previous mole
  // the next index is used instead; NUM_MOLES is a power of two, so the
  // natural wrap of the MW-bit add gives the modulo. The first pop-up of a
  // game has no predecessor and is taken as-is.
  always_comb begin
    pick = lfsr[MW-1:0];
    if ((round_cnt != 8'd0) && (pick == mole)) begin
      pick = pick + MW'(1);
    end
  end

  // Next-state and datapath logic. Everything holds by default; the LFSR
  // free-runs every cycle and the timer counts down on each ms tick unless
  // a state transition reloads it.
  always_comb begin
    state_d     = state;
    timer_d     = timer;
    round_cnt_d = round_cnt;
    score_d     = score_q;
    misses_d    = misses_q;
    mole_d      = mole;
    lfsr_d      = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

    if (ms_tick && (timer != '0)) begin
      timer_d = timer - TW'(1);
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d     = GAP;
          timer_d     = GAP_LOAD;
          round_cnt_d = 8'd0;
          score_d     = 8'd0;
          misses_d    = 8'd0;
        end
      end

      GAP: begin
        if (expire) begin
          state_d = UP;
          timer_d = up_load;
          mole_d  = pick;
        end
      end

      UP: begin
        // A hit wins over a timeout landing on the same cycle.
        if (hit || expire) begin
          if (hit) begin
            score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          end else begin
            misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
          end
          round_cnt_d = next_cnt;
          if (next_cnt == ROUNDS_L) begin
            state_d = DONE;
            timer_d = '0;
          end else begin
            state_d = GAP;
            timer_d = GAP_LOAD;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset aborts a game immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      timer     <= '0;
      round_cnt <= 8'd0;
      score_q   <= 8'd0;
      misses_q  <= 8'd0;
      mole      <= '0;
      lfsr      <= LFSR_SEED;
    end else begin
      state     <= state_d;
      timer     <= timer_d;
      round_cnt <= round_cnt_d;
      score_q   <= score_d;
      misses_q  <= misses_d;
      mole      <= mole_d;
      lfsr      <= lfsr_d;
    end
  end

  // Outputs come straight from registers, so leds fall as soon as reset
  // clears the state register.
  assign leds        = (state == UP) ? (NUM_MOLES'(1) << mole) : '0;
  assign active_mole = mole;
  assign score       = score_q;
  assign misses      = misses_q;
  assign busy        = (state == GAP) || (state == UP);
  assign game_over   = (state == DONE);

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Testbench for mole_round_scheduler.
// Instance a: 4 moles, 3 rounds, 5 ms gap (short games, corner cases).
// Instance b: 4 moles, 255 rounds, 2 ms gap (long run, every mole hit).
// ms_tick is shared and pulses once every 4 clocks.

module tb_mole_round_scheduler;

  localparam int NM = 4;
  localparam int TW = 11;

  logic          clk;
  logic          reset;
  logic          ms_tick;
  logic          start_a, start_b;
  logic [TW-1:0] up_ms_a, up_ms_b;
  logic [NM-1:0] buttons_a, buttons_b;
  logic [NM-1:0] leds_a, leds_b;
  logic [1:0]    active_mole_a, active_mole_b;
  logic [7:0]    score_a, score_b, misses_a, misses_b;
  logic          busy_a, busy_b, game_over_a, game_over_b;

  int tests_run    = 0;
  int tests_failed = 0;
  int phase        = 0;
  bit ticked       = 0;

  mole_round_scheduler #(
    .NUM_MOLES(4), .MAX_MS(2047), .GAP_MS(5), .ROUNDS(3), .LFSR_SEED(8'hA5)
  ) dut_a (
    .clk(clk), .reset(reset), .ms_tick(ms_tick), .start(start_a),
    .up_ms(up_ms_a), .buttons(buttons_a), .leds(leds_a),
    .active_mole(active_mole_a), .score(score_a), .misses(misses_a),
    .busy(busy_a), .game_over(game_over_a)
  );

  mole_round_scheduler #(
    .NUM_MOLES(4), .MAX_MS(2047), .GAP_MS(2), .ROUNDS(255), .LFSR_SEED(8'hA5)
  ) dut_b (
    .clk(clk), .reset(reset), .ms_tick(ms_tick), .start(start_b),
    .up_ms(up_ms_b), .buttons(buttons_b), .leds(leds_b),
    .active_mole(active_mole_b), .score(score_b), .misses(misses_b),
    .busy(busy_b), .game_over(game_over_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge: drives one cycle of inputs, then waits for the
  // next falling edge so outputs reflect the rising edge that sampled them.
  task automatic applyStimulus(input logic st_a, input logic st_b,
                               input logic [NM-1:0] btn_a,
                               input logic [NM-1:0] btn_b);
    start_a   = st_a;
    start_b   = st_b;
    buttons_a = btn_a;
    buttons_b = btn_b;
    ticked    = (phase == 3);
    ms_tick   = (phase == 3);
    phase     = (phase + 1) % 4;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, '0, '0);
  endtask

  // Runs idle cycles until the chosen instance's LEDs reach the wanted
  // on/off condition, returning how many ms ticks were applied meanwhile.
  task automatic waitLeds(input string tag, input bit sel, input bit want_on,
                          input int bound, output int ticks);
    int n;
    logic on;
    n     = 0;
    ticks = 0;
    on    = sel ? (leds_b != '0) : (leds_a != '0);
    while ((n < bound) && (on != want_on)) begin
      idleCycle();
      if (ticked) ticks++;
      n++;
      on = sel ? (leds_b != '0) : (leds_a != '0);
    end
    checkOutput(tag, {31'b0, on}, {31'b0, want_on});
  endtask

  task automatic advanceTicks(input int n);
    int cnt;
    cnt = 0;
    while (cnt < n) begin
      idleCycle();
      if (ticked) cnt++;
    end
  endtask

  // Idles until the next applied cycle will carry an ms tick.
  task automatic toTick();
    while (phase != 3) idleCycle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t;
    logic [NM-1:0] btn;
    logic [NM-1:0] lit;
    int repeats;
    int onehot_err;
    int prev;
    int idx;
    int visited_cnt;
    bit [NM-1:0] visited;

    reset     = 1'b1;
    ms_tick   = 1'b0;
    start_a   = 1'b0;
    start_b   = 1'b0;
    buttons_a = '0;
    buttons_b = '0;
    up_ms_a   = 11'd10;
    up_ms_b   = 11'd3;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_leds_a", leds_a, 0);
    checkOutput("rst_score_a", score_a, 0);
    checkOutput("rst_misses_a", misses_a, 0);
    checkOutput("rst_busy_a", busy_a, 0);
    checkOutput("rst_over_a", game_over_a, 0);
    checkOutput("rst_mole_a", active_mole_a, 0);
    checkOutput("rst_leds_b", leds_b, 0);
    checkOutput("rst_busy_b", busy_b, 0);
    reset = 1'b0;

    // 1: three unanswered pop-ups, 5 ms dark then 10 ms lit each
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t1_busy", busy_a, 1);
    checkOutput("t1_leds_gap", leds_a, 0);
    for (int r = 0; r < 3; r++) begin
      waitLeds("t1_wait_up", 1'b0, 1'b1, 200, t);
      checkOutput("t1_gap_ticks", t, 5);
      checkOutput("t1_onehot", $countones(leds_a), 1);
      waitLeds("t1_wait_down", 1'b0, 1'b0, 200, t);
      checkOutput("t1_up_ticks", t, 10);
      checkOutput("t1_misses", misses_a, r + 1);
    end
    checkOutput("t1_over", game_over_a, 1);
    checkOutput("t1_score", score_a, 0);
    checkOutput("t1_misses_end", misses_a, 3);
    checkOutput("t1_busy_end", busy_a, 0);
    checkOutput("t1_leds_end", leds_a, 0);

    // 2: hit on the third tick; later presses and start in GAP are ignored
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t2_restart_score", score_a, 0);
    checkOutput("t2_restart_misses", misses_a, 0);
    checkOutput("t2_restart_over", game_over_a, 0);
    checkOutput("t2_restart_busy", busy_a, 1);
    waitLeds("t2_wait_up", 1'b0, 1'b1, 200, t);
    btn = leds_a;
    advanceTicks(2);
    toTick();
    applyStimulus(1'b0, 1'b0, btn, '0);
    checkOutput("t2_hit_leds", leds_a, 0);
    checkOutput("t2_hit_score", score_a, 1);
    checkOutput("t2_hit_misses", misses_a, 0);
    checkOutput("t2_hit_busy", busy_a, 1);
    applyStimulus(1'b1, 1'b0, btn, '0);
    checkOutput("t2_gap_score", score_a, 1);
    checkOutput("t2_gap_misses", misses_a, 0);
    checkOutput("t2_gap_busy", busy_a, 1);

    // 3: hit landing on the expiring tick counts as a hit only
    waitLeds("t3_wait_up", 1'b0, 1'b1, 200, t);
    btn = leds_a;
    advanceTicks(9);
    toTick();
    applyStimulus(1'b0, 1'b0, btn, '0);
    checkOutput("t3_score", score_a, 2);
    checkOutput("t3_misses", misses_a, 0);
    checkOutput("t3_leds", leds_a, 0);
    checkOutput("t3_busy", busy_a, 1);
    up_ms_a = 11'd0;

    // 4: wrong button ignored; a zero window lasts a single tick
    waitLeds("t4_wait_up", 1'b0, 1'b1, 200, t);
    lit = leds_a;
    btn = {lit[NM-2:0], lit[NM-1]};
    applyStimulus(1'b0, 1'b0, btn, '0);
    checkOutput("t4_wrong_leds", leds_a, lit);
    checkOutput("t4_wrong_score", score_a, 2);
    checkOutput("t4_wrong_misses", misses_a, 0);
    waitLeds("t4_wait_down", 1'b0, 1'b0, 200, t);
    checkOutput("t4_up_ticks", t, 1);
    checkOutput("t4_misses", misses_a, 1);
    checkOutput("t4_score", score_a, 2);
    checkOutput("t4_over", game_over_a, 1);

    // 5: asynchronous reset in the middle of a lit window
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t5_start_score", score_a, 0);
    checkOutput("t5_start_misses", misses_a, 0);
    waitLeds("t5_wait_up1", 1'b0, 1'b1, 200, t);
    applyStimulus(1'b0, 1'b0, leds_a, '0);
    checkOutput("t5_hit_score", score_a, 1);
    waitLeds("t5_wait_up2", 1'b0, 1'b1, 200, t);
    #2 reset = 1'b1;
    #1;
    checkOutput("t5_rst_leds", leds_a, 0);
    checkOutput("t5_rst_busy", busy_a, 0);
    checkOutput("t5_rst_score", score_a, 0);
    checkOutput("t5_rst_over", game_over_a, 0);
    @(negedge clk);
    reset   = 1'b0;
    up_ms_a = 11'd10;
    applyStimulus(1'b1, 1'b0, '0, '0);
    checkOutput("t5_restart_busy", busy_a, 1);
    checkOutput("t5_restart_score", score_a, 0);
    waitLeds("t5_wait_up3", 1'b0, 1'b1, 200, t);
    checkOutput("t5_restart_gap", t, 5);

    // 6: long game on instance b, every mole hit immediately
    repeats     = 0;
    onehot_err  = 0;
    visited     = '0;
    prev        = -1;
    applyStimulus(1'b0, 1'b1, '0, '0);
    for (int r = 0; r < 255; r++) begin
      waitLeds("t6_wait_up", 1'b1, 1'b1, 100, t);
      if ($countones(leds_b) != 1) onehot_err++;
      idx = 0;
      for (int i = 0; i < NM; i++) if (leds_b[i]) idx = i;
      if (idx == prev) repeats++;
      prev = idx;
      visited[idx] = 1'b1;
      applyStimulus(1'b0, 1'b0, '0, leds_b);
    end
    visited_cnt = $countones(visited);
    checkOutput("t6_score", score_b, 255);
    checkOutput("t6_misses", misses_b, 0);
    checkOutput("t6_over", game_over_b, 1);
    checkOutput("t6_leds", leds_b, 0);
    checkOutput("t6_repeats", repeats, 0);
    checkOutput("t6_onehot", onehot_err, 0);
    checkOutput("t6_visited", visited_cnt, NM);
    applyStimulus(1'b0, 1'b1, '0, '0);
    checkOutput("t6_restart_score", score_b, 0);
    checkOutput("t6_restart_busy", busy_b, 1);
    checkOutput("t6_restart_over", game_over_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
